line_window_scanner: RTL and testbench
======================================

# line_window_scanner

Producer side of the chess-form judging path. For one board point it reads the 9-cell line through that point in each of the four directions from board storage. It packs each line into the own/opponent bit-window pair that the form judge consumes, then streams the four windows out over a valid/ready handshake. It sits between the board register file and the form judge inside the move-evaluation loop.

## Interface
- BOARD_N, 15, board side length; legal values 5..16, because the address is fixed at 8 bits.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- row  in  4  center row, latched on an accepted start.
- col  in  4  center column, latched on an accepted start.
- player  in  1  own colour: 0 = black (code 01), 1 = white (code 10).
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the scan ends.
- err  out  1  valid with done; 1 means the center was off board.
- rd_en  out  1  board read strobe.
- rd_addr  out  8  board address, row*BOARD_N+col.
- rd_data  in  2  cell code, valid one cycle after rd_en; 00 empty, 01 black, 10 white, 11 read as empty.
- win_valid  out  1  a window is presented.
- win_ready  in  1  the judge accepts the window.
- win_a  out  9  own-stone window; bit i is offset i-4, bit 4 is the center.
- win_b  out  9  opponent-stone window, same bit order.
- win_dir  out  2  0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
- win_last  out  1  high with the dir-3 window.

## Operation
- Direction steps (dr,dc):
  - dir 0 = (0,+1)
  - dir 1 = (+1,0)
  - dir 2 = (+1,+1)
  - dir 3 = (+1,-1)
- Cell k (0..8) is at (row+(k-4)·dr, col+(k-4)·dc). Compute it in signed 6-bit arithmetic. A cell is off board if its row or column is <0 or >=BOARD_N.
- FSM states: IDLE, CHECK, READ, PRESENT, DONE.
  - IDLE, start=1 → CHECK. Latch row, col, player; clear both windows; dir=0.
  - CHECK → DONE with err=1 if row>=BOARD_N or col>=BOARD_N. Otherwise → READ.
  - READ issues slots k=0..8, one per cycle.
    - On-board slot: rd_en=1 with that cell's address.
    - Off-board slot: rd_en=0, and the cell is marked per Configuration.
    - Returned data is written to bit k the next cycle: own code → win_a[k], other colour → win_b[k], empty → neither.
    - After the slot-8 data is captured → PRESENT.
  - PRESENT holds win_valid=1.
    - On win_valid&&win_ready: if dir<3, dir+1, clear both windows → READ.
    - If dir=3 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start while busy is ignored.
- win_a, win_b, win_dir and win_last are stable while win_valid=1 and win_ready=0. No reads are issued in PRESENT.
- rd_en is never high outside READ.
- win_a and win_b are never both 1 at any bit.

## Timing
- Reset values: busy, done, err, rd_en, win_valid and win_last are 0; rd_addr, win_a, win_b and win_dir are 0; state is IDLE.
- Reset asserted mid-scan aborts immediately. No done pulse follows. The next start rescans from dir 0.
- Start accepted at cycle 0:
  - busy=1 at cycle 1.
  - First read slot at cycle 2.
  - First win_valid at cycle 12.
- Each direction costs 10 cycles (9 slots plus 1 cycle for capture) plus the handshake wait.
- With win_ready tied to 1:
  - Windows appear at cycles 12, 23, 34 and 45.
  - done is at cycle 46; busy falls at cycle 47.
- Invalid center: done=1 and err=1 at cycle 2, no windows presented.
- err is cleared on the next accepted start.

## Configuration
- EDGE_AS_OPPONENT_EN defined: each off-board cell sets win_b[k]=1, so the board edge blocks a line exactly as an opponent stone does.
- Not defined: off-board cells leave both win_a[k] and win_b[k] at 0.
- In both builds, off-board slots issue no read.

## Test plan
- Empty board, center (7,7), player 0, ready tied 1 → four windows with a=0, b=0, dir 0..3, win_last only on the fourth. done at cycle 46; 36 rd_en pulses.
- Black at (7,5)..(7,8), white at (7,9), center (7,7), player 0 → dir 0 window a=9'b000111100, b=9'b001000000. With player 1, a and b are swapped.
- Empty board, center (0,0), macro defined:
  - dir 0, 1 and 2: b=9'b000001111.
  - dir 3: b=9'b111101111.
  - Without the macro, all b=0.
  - rd_en counts are 5, 5, 5 and 1.
- win_ready held low for 5 cycles on the dir-1 window → outputs stable, rd_en=0 throughout. Window accepted on the first ready cycle; dir-2 reads start the next cycle.
- Center (15,3) → done=1, err=1 at cycle 2; win_valid and rd_en never asserted.
- rst_n pulsed low during dir-2 READ → all outputs 0 asynchronously, no done. A fresh start then produces the full four-window sequence.

Source files
------------

// File: rtl/line_window_scanner.sv
// line_window_scanner: reads the 9-cell line through a board point in four directions and streams own/opponent windows.
// Optional EDGE_AS_OPPONENT_EN: off-board cells are marked as opponent stones in win_b.
module line_window_scanner #(
   parameter int BOARD_N = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] row,
   input  logic [3:0] col,
   input  logic       player,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       rd_en,
   output logic [7:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic       win_valid,
   input  logic       win_ready,
   output logic [8:0] win_a,
   output logic [8:0] win_b,
   output logic [1:0] win_dir,
   output logic       win_last
);
   typedef enum logic [2:0] {IDLE, CHECK, READ, PRESENT, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] row_q, row_d, col_q, col_d, k_q, k_d;
   logic [1:0] dir_q, dir_d;
   logic [8:0] a_q, a_d, b_q, b_d;
   logic [7:0] rd_addr_q, rd_addr_d;
   logic [11:0] nxt_p;
   logic [1:0] own;
   logic player_q, player_d, cap_q, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic rd_en_q, rd_en_d, valid_q, valid_d, last_q, last_d;

   // {row, col} of cell k as signed 6-bit pairs
   function automatic logic [11:0] pos(input logic [3:0] k, input logic [1:0] d,
                                       input logic [3:0] r0, input logic [3:0] c0);
      logic signed [5:0] o, r, c;
      o = $signed({2'b00, k}) - 6'sd4;
      r = $signed({2'b00, r0}) + (d == 2'd0 ? 6'sd0 : o);
      c = $signed({2'b00, c0}) + (d == 2'd1 ? 6'sd0 : d == 2'd3 ? -o : o);
      return {r, c};
   endfunction

   function automatic logic on_board(input logic [11:0] p);
      return !p[11] && !p[5] && p[10:6] < 5'(BOARD_N) && p[4:0] < 5'(BOARD_N);
   endfunction

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      player_d = player_q;
      k_d      = k_q;
      dir_d    = dir_q;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      own      = player_q ? 2'b10 : 2'b01;
      case (state_q)
         IDLE: if (start) begin
            state_d  = CHECK;
            row_d    = row;
            col_d    = col;
            player_d = player;
            a_d      = '0;
            b_d      = '0;
            dir_d    = '0;
            err_d    = 1'b0;
         end
         CHECK: begin
            k_d     = '0;
            err_d   = 5'(row_q) >= 5'(BOARD_N) || 5'(col_q) >= 5'(BOARD_N);
            state_d = err_d ? DONE : READ;
         end
         READ: begin
            // data for the slot issued last cycle lands now, one bit behind k_q
            if (cap_q) begin
               a_d[k_q - 4'd1] = rd_data == own;
               b_d[k_q - 4'd1] = rd_data == ~own;
            end
`ifdef EDGE_AS_OPPONENT_EN
            if (k_q <= 4'd8 && !on_board(pos(k_q, dir_q, row_q, col_q))) b_d[k_q] = 1'b1;
`endif
            k_d = k_q + 4'd1;
            if (k_q == 4'd9) state_d = PRESENT;
         end
         PRESENT: if (win_ready) begin
            if (dir_q == 2'd3) state_d = DONE;
            else begin
               state_d = READ;
               dir_d   = dir_q + 2'd1;
               k_d     = '0;
               a_d     = '0;
               b_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered, so they are derived from the next state
      nxt_p     = pos(k_d, dir_d, row_d, col_d);
      rd_en_d   = state_d == READ && k_d <= 4'd8 && on_board(nxt_p);
      rd_addr_d = rd_en_d ? 8'(nxt_p[9:6]) * 8'(BOARD_N) + 8'(nxt_p[3:0]) : rd_addr_q;
      busy_d    = state_d != IDLE;
      done_d    = state_d == DONE;
      valid_d   = state_d == PRESENT;
      last_d    = state_d == PRESENT && dir_d == 2'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         player_q  <= 1'b0;
         k_q       <= '0;
         dir_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rd_addr_q <= '0;
         cap_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         player_q  <= player_d;
         k_q       <= k_d;
         dir_q     <= dir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rd_addr_q <= rd_addr_d;
         cap_q     <= rd_en_q;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rd_en_q   <= rd_en_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign win_valid = valid_q;
   assign win_a     = a_q;
   assign win_b     = b_q;
   assign win_dir   = dir_q;
   assign win_last  = last_q;
endmodule

// File: tb/tb_line_window_scanner.sv
// tb_line_window_scanner: directed scenarios for line_window_scanner with a behavioural board memory.
module tb_line_window_scanner;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, player = 1'b0, win_ready = 1'b1;
   logic [3:0] row = '0, col = '0;
   logic [1:0] rd_data = '0;
   logic busy, done, err, rd_en, win_valid, win_last;
   logic [7:0] rd_addr;
   logic [8:0] win_a, win_b;
   logic [1:0] win_dir;
   logic [1:0] board [256];
   int errors = 0, checks = 0;

   logic [8:0] wa [4], wb [4];
   logic [1:0] wd [4];
   logic wl [4];
   int wcyc [4], rdc [4];
   int nwin, vcount, done_cyc, rd_total, acc_cyc, rd_after;
   logic err_done, busy1, err1, busy_after, overlap, stall_bad, stall_rd;

   line_window_scanner #(.BOARD_N(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .row(row), .col(col), .player(player),
      .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_a(win_a), .win_b(win_b),
      .win_dir(win_dir), .win_last(win_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rd_data <= rd_en ? board[rd_addr] : 2'b11;

   task automatic clear_board();
      foreach (board[i]) board[i] = 2'b00;
   endtask

   task automatic pattern_board();
      clear_board();
      for (int c = 5; c <= 8; c++) board[7*15+c] = 2'b01;
      board[7*15+9] = 2'b10;
      board[7*15+3] = 2'b11;
   endtask

   // runs one scan; n counts cycles with the accepted start edge ending cycle 0
   task automatic run_scan(input logic [3:0] r, input logic [3:0] c, input logic p, input int stall_dir);
      int n, stall;
      logic [8:0] sa, sb;
      nwin = 0; vcount = 0; done_cyc = -1; rd_total = 0; acc_cyc = -1; rd_after = -1;
      overlap = 0; stall_bad = 0; stall_rd = 0; stall = 0; sa = '0; sb = '0;
      for (int i = 0; i < 4; i++) begin rdc[i] = 0; wcyc[i] = -1; wa[i] = 'x; wb[i] = 'x; end
      @(negedge clk);
      row = r; col = c; player = p; start = 1'b1; win_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; n = 1; busy1 = busy; err1 = err;
      while (n < 300 && done_cyc < 0) begin
         if (done) begin done_cyc = n; err_done = err; end
         if (rd_en) begin
            rd_total++;
            if (nwin < 4) rdc[nwin]++;
            if (acc_cyc >= 0 && rd_after < 0) rd_after = n;
         end
         if ((win_a & win_b) != 9'd0) overlap = 1;
         if (win_valid) vcount++;
         win_ready = 1'b1;
         if (win_valid && int'(win_dir) == stall_dir && stall < 5) begin
            if (stall == 0) begin sa = win_a; sb = win_b; end
            else if (win_a !== sa || win_b !== sb || win_valid !== 1'b1) stall_bad = 1;
            if (rd_en) stall_rd = 1;
            win_ready = 1'b0;
            stall++;
         end
         if (win_valid && win_ready && nwin < 4) begin
            wa[nwin] = win_a; wb[nwin] = win_b; wd[nwin] = win_dir; wl[nwin] = win_last; wcyc[nwin] = n;
            if (int'(win_dir) == stall_dir) acc_cyc = n;
            nwin++;
         end
         @(posedge clk); #1;
         n++;
      end
      busy_after = busy;
   endtask

   task automatic test_reset();
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({busy, done, err, rd_en, win_valid, win_last, rd_addr, win_a, win_b, win_dir} !== 34'd0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", {busy, done, err, rd_en, win_valid, win_last, rd_addr, win_a, win_b, win_dir});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++;
      if ({busy, done, rd_en, win_valid} !== 4'd0) begin
         errors++; $display("FAIL idle_after_reset: got %b required 0000", {busy, done, rd_en, win_valid});
      end
   endtask

   task automatic test_empty();
      clear_board();
      run_scan(4'd7, 4'd7, 1'b0, -1);
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL empty_busy_c1: got %b required 1", busy1); end
      checks++; if (nwin !== 4) begin errors++; $display("FAIL empty_nwin: got %0d required 4", nwin); end
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (wa[d] !== 9'd0 || wb[d] !== 9'd0 || wd[d] !== 2'(d) || wl[d] !== (d == 3) || wcyc[d] !== 12 + 11*d) begin
            errors++;
            $display("FAIL empty_win%0d: got a=%b b=%b dir=%0d last=%b cyc=%0d required a=0 b=0 dir=%0d last=%0d cyc=%0d",
                     d, wa[d], wb[d], wd[d], wl[d], wcyc[d], d, d == 3, 12 + 11*d);
         end
      end
      checks++; if (done_cyc !== 46) begin errors++; $display("FAIL empty_done_cyc: got %0d required 46", done_cyc); end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL empty_busy_c47: got %b required 0", busy_after); end
      checks++; if (rd_total !== 36) begin errors++; $display("FAIL empty_rd_count: got %0d required 36", rd_total); end
      checks++; if (err_done !== 1'b0) begin errors++; $display("FAIL empty_err: got %b required 0", err_done); end
   endtask

   task automatic test_pattern();
      pattern_board();
      run_scan(4'd7, 4'd7, 1'b0, -1);
      checks++;
      if (wa[0] !== 9'b000111100 || wb[0] !== 9'b001000000) begin
         errors++; $display("FAIL pat_p0_dir0: got a=%b b=%b required a=000111100 b=001000000", wa[0], wb[0]);
      end
      checks++;
      if (wa[1] !== 9'b000010000 || wb[1] !== 9'd0) begin
         errors++; $display("FAIL pat_p0_dir1: got a=%b b=%b required a=000010000 b=0", wa[1], wb[1]);
      end
      checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL pat_overlap: got %b required 0", overlap); end
      run_scan(4'd7, 4'd7, 1'b1, -1);
      checks++;
      if (wa[0] !== 9'b001000000 || wb[0] !== 9'b000111100) begin
         errors++; $display("FAIL pat_p1_dir0: got a=%b b=%b required a=001000000 b=000111100", wa[0], wb[0]);
      end
      checks++;
      if (wa[3] !== 9'd0 || wb[3] !== 9'b000010000) begin
         errors++; $display("FAIL pat_p1_dir3: got a=%b b=%b required a=0 b=000010000", wa[3], wb[3]);
      end
   endtask

   task automatic test_edge();
      logic [8:0] exp_b [4];
`ifdef EDGE_AS_OPPONENT_EN
      exp_b = '{9'b000001111, 9'b000001111, 9'b000001111, 9'b111101111};
`else
      exp_b = '{9'd0, 9'd0, 9'd0, 9'd0};
`endif
      clear_board();
      run_scan(4'd0, 4'd0, 1'b0, -1);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (wa[d] !== 9'd0 || wb[d] !== exp_b[d]) begin
            errors++; $display("FAIL edge_win%0d: got a=%b b=%b required a=0 b=%b", d, wa[d], wb[d], exp_b[d]);
         end
         checks++;
         if (rdc[d] !== (d == 3 ? 1 : 5)) begin
            errors++; $display("FAIL edge_rd%0d: got %0d required %0d", d, rdc[d], d == 3 ? 1 : 5);
         end
      end
   endtask

   task automatic test_back_pressure();
      pattern_board();
      run_scan(4'd7, 4'd7, 1'b0, 1);
      checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b required 0", stall_bad); end
      checks++; if (stall_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_en: got %b required 0", stall_rd); end
      checks++; if (wcyc[1] !== 28) begin errors++; $display("FAIL bp_accept_cyc: got %0d required 28", wcyc[1]); end
      checks++; if (rd_after !== 29) begin errors++; $display("FAIL bp_dir2_read: got %0d required 29", rd_after); end
      checks++; if (wa[1] !== 9'b000010000) begin errors++; $display("FAIL bp_dir1_a: got %b required 000010000", wa[1]); end
      checks++; if (done_cyc !== 51) begin errors++; $display("FAIL bp_done_cyc: got %0d required 51", done_cyc); end
   endtask

   task automatic test_invalid();
      run_scan(4'd15, 4'd3, 1'b0, -1);
      checks++;
      if (done_cyc !== 2 || err_done !== 1'b1) begin
         errors++; $display("FAIL inv_done: got cyc=%0d err=%b required cyc=2 err=1", done_cyc, err_done);
      end
      checks++;
      if (vcount !== 0 || rd_total !== 0) begin
         errors++; $display("FAIL inv_activity: got valid=%0d rd=%0d required 0 0", vcount, rd_total);
      end
   endtask

   task automatic test_abort();
      logic seen_done;
      clear_board();
      @(negedge clk);
      row = 4'd7; col = 4'd7; player = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b required 0", err); end
      repeat (27) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({busy, done, err, rd_en, win_valid, win_last, rd_addr, win_a, win_b, win_dir} !== 34'd0) begin
         errors++; $display("FAIL abort_async: got %h required 0", {busy, done, err, rd_en, win_valid, win_last, rd_addr, win_a, win_b, win_dir});
      end
      seen_done = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; if (done || busy) seen_done = 1'b1; end
      checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b required 0", seen_done); end
      run_scan(4'd7, 4'd7, 1'b0, -1);
      checks++;
      if (nwin !== 4 || wd[0] !== 2'd0 || wd[3] !== 2'd3 || done_cyc !== 46) begin
         errors++; $display("FAIL abort_rescan: got nwin=%0d dir0=%0d dir3=%0d done=%0d required 4 0 3 46", nwin, wd[0], wd[3], done_cyc);
      end
   endtask

   initial begin
      clear_board();
      test_reset();
      test_empty();
      test_pattern();
      test_edge();
      test_back_pressure();
      test_invalid();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
